// File: rtl/aes_encrypt_core.sv
// rtl/aes_encrypt_core.sv - iterative AES-128 encryption core, one round per clock
//
// Purpose:
//   Encrypts one 128-bit block with a pre-expanded AES-128 key schedule.
//   The initial AddRoundKey is applied on accept. Each later edge runs one
//   full round (the tenth omits MixColumns). The result is held until the
//   consumer takes it.
//
// Ports:
//   clk         in   1     rising-edge clock
//   n_rst       in   1     asynchronous active-low reset
//   roundKeys   in   1408  round key i at [128*i+127:128*i], i = 0..10
//   in_valid    in   1     plaintext offered
//   in_ready    out  1     core idle and able to accept
//   plaintext   in   128   input block, byte 0 at [127:120], column-major
//   out_valid   out  1     ciphertext available
//   out_ready   in   1     consumer takes ciphertext
//   ciphertext  out  128   result block, same byte order as plaintext
//   busy        out  1     block in flight or awaiting pickup

module aes_encrypt_core (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [1407:0] roundKeys,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  plaintext,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  ciphertext,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ROUND = 2'b01,
    DONE  = 2'b10
  } fsm_t;

  // S-box packed with entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return SBOX[idx -: 8];
  endfunction

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One encryption round. State byte i = s[row i%4][col i/4].
  function automatic logic [127:0] aes_round(
    input logic [127:0] s,
    input logic [127:0] k,
    input logic         last
  );
    logic [7:0]   sb [0:15];
    logic [7:0]   sr [0:15];
    logic [7:0]   mc [0:15];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(s[127-8*i -: 8]);
    end
    // Row r rotates left by r columns.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr[r+4*c] = sb[r+4*((c+r)%4)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    for (int i = 0; i < 16; i++) begin
      res[127-8*i -: 8] = (last ? sr[i] : mc[i]) ^ k[127-8*i -: 8];
    end
    return res;
  endfunction

  fsm_t         state, state_nxt;
  logic [127:0] state_reg, state_reg_nxt;
  logic [3:0]   round_cnt, round_cnt_nxt;
  logic [3:0]   key_sel;
  logic [127:0] round_key;
  logic [127:0] round_out;

  // Clamp keeps the key select inside the 11 keys even for counter values
  // that the FSM treats as corrupt and never uses.
  assign key_sel   = (round_cnt > 4'd10) ? 4'd10 : round_cnt;
  assign round_key = roundKeys[{key_sel, 7'd0} +: 128];
  assign round_out = aes_round(state_reg, round_key, round_cnt == 4'd10);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      state_reg <= '0;
      round_cnt <= '0;
    end else begin
      state     <= state_nxt;
      state_reg <= state_reg_nxt;
      round_cnt <= round_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    state_reg_nxt = state_reg;
    round_cnt_nxt = round_cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_reg_nxt = plaintext ^ roundKeys[127:0];
          round_cnt_nxt = 4'd1;
          state_nxt     = ROUND;
        end
      end
      ROUND: begin
        if (round_cnt == 4'd0 || round_cnt > 4'd10) begin
          state_nxt = IDLE;
        end else begin
          state_reg_nxt = round_out;
          if (round_cnt == 4'd10) begin
            state_nxt = DONE;
          end else begin
            round_cnt_nxt = round_cnt + 4'd1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Handshake outputs decode only the registered state, so reset reaches
  // them without a clock and no input feeds through combinationally.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      ROUND:   busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  assign ciphertext = state_reg;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// tb/tb_aes_encrypt_core.sv - directed self-checking bench for aes_encrypt_core

module tb_aes_encrypt_core;

  logic          clk;
  logic          n_rst;
  logic [1407:0] roundKeys;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  plaintext;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  ciphertext;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  localparam logic [2047:0] TB_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  aes_encrypt_core dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .roundKeys  (roundKeys),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] tb_sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return TB_SBOX[idx -: 8];
  endfunction

  // AES-128 key expansion into the 11-key layout the core expects.
  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [0:43];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] rk;
    w[0] = key[127:96];
    w[1] = key[95:64];
    w[2] = key[63:32];
    w[3] = key[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])}
            ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      rk[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return rk;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accepts one block (core must be idle) and waits for out_valid.
  // lat = edges from accept to out_valid, 21 on timeout.
  // With pulse set, a ffff..ff block is offered across the round-4 edge.
  task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                           input logic pulse, output int lat);
    roundKeys = expand(key);
    plaintext = pt;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    plaintext = '0;
    lat = 21;
    for (int i = 1; i <= 20; i++) begin
      if (pulse && i == 4) begin
        in_valid  = 1'b1;
        plaintext = {128{1'b1}};
      end
      tick();
      in_valid = 1'b0;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int extra;
    int nacc;
    int nres;
    int acc [0:1];

    n_rst     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plaintext = '0;
    roundKeys = '0;

    // Reset state before any clock edge.
    #2;
    check("rst_in_ready",   128'(in_ready),  128'(1));
    check("rst_out_valid",  128'(out_valid), 128'(0));
    check("rst_busy",       128'(busy),      128'(0));
    check("rst_ciphertext", ciphertext,      128'h0);
    tick();
    tick();
    @(negedge clk);
    n_rst = 1'b1;
    tick();

    // Appendix B vector, latency and backpressure.
    run_block(KEY_B, PT_B, 1'b0, lat);
    check("b_latency",    128'(lat),       128'(10));
    check("b_ciphertext", ciphertext,      CT_B);
    check("b_busy_done",  128'(busy),      128'(1));
    check("b_in_ready",   128'(in_ready),  128'(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid",  128'(out_valid), 128'(1));
      check("bp_ciphertext", ciphertext,      CT_B);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("rel_out_valid", 128'(out_valid), 128'(0));
    check("rel_in_ready",  128'(in_ready),  128'(1));
    check("rel_ct_kept",   ciphertext,      CT_B);

    // Busy rejection: extra offer during round 4 must be ignored.
    run_block(KEY_B, PT_B, 1'b1, lat);
    check("rej_latency",    128'(lat),  128'(10));
    check("rej_ciphertext", ciphertext, CT_B);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    extra = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (out_valid || busy) extra++;
    end
    check("rej_no_extra", 128'(extra), 128'(0));

    // Reset during round 5, then a clean Appendix C.1 run.
    roundKeys = expand(KEY_C);
    plaintext = PT_C;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_busy", 128'(busy), 128'(1));
    #2;
    n_rst = 1'b0;
    #1;
    check("mid_in_ready",   128'(in_ready),  128'(1));
    check("mid_out_valid",  128'(out_valid), 128'(0));
    check("mid_busy_rst",   128'(busy),      128'(0));
    check("mid_ciphertext", ciphertext,      128'h0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    run_block(KEY_C, PT_C, 1'b0, lat);
    check("c_latency",    128'(lat),  128'(10));
    check("c_ciphertext", ciphertext, CT_C);
    out_ready = 1'b1;
    tick();

    // Back-to-back: C.1 block then B block with in_valid/out_ready held.
    roundKeys = expand(KEY_C);
    plaintext = PT_C;
    in_valid  = 1'b1;
    nacc = 0;
    nres = 0;
    acc[0] = 0;
    acc[1] = 0;
    for (int k = 0; k < 40 && nres < 2; k++) begin
      if (in_ready && in_valid && nacc < 2) begin
        acc[nacc] = cyc + 1;
        nacc++;
      end
      tick();
      if (nacc == 2) in_valid = 1'b0;
      if (out_valid) begin
        nres++;
        if (nres == 1) begin
          check("b2b_first", ciphertext, CT_C);
          roundKeys = expand(KEY_B);
          plaintext = PT_B;
        end else begin
          check("b2b_second", ciphertext, CT_B);
        end
      end
    end
    check("b2b_results", 128'(nres),            128'(2));
    check("b2b_spacing", 128'(acc[1] - acc[0]), 128'(12));
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
